// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - retirement record types, checker states and compare helpers
package riscv_trace_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        REG  = 2'd1,
        MEM  = 2'd2
    } retire_kind_t;

    typedef struct packed {
        logic [31:0]  pc;
        retire_kind_t kind;
        logic [4:0]   rd;
        logic [31:0]  value;
        logic [31:0]  addr;
        logic         finish;
    } retire_rec_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_FAIL = 2'd2
    } check_state_t;

    // A write to x0 has no architectural effect, so it compares like NONE.
    function automatic retire_rec_t normalize(input retire_rec_t rec);
        retire_rec_t n;
        n = rec;
        if (rec.kind == REG && rec.rd == 5'd0) begin
            n.kind = NONE;
        end
        return n;
    endfunction

    function automatic logic recordsMatch(input retire_rec_t actual, input retire_rec_t golden);
        logic ok;
        ok = (actual.pc == golden.pc) && (actual.kind == golden.kind)
             && (actual.finish == golden.finish);
        case (actual.kind)
            REG:     ok = ok && (actual.rd == golden.rd) && (actual.value == golden.value);
            MEM:     ok = ok && (actual.addr == golden.addr) && (actual.value == golden.value);
            default: ok = ok;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - synchronous FIFO of retirement records with wrap-bit pointers
module retire_fifo
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  retire_rec_t   pushRec,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output retire_rec_t   head,
    output logic [AW:0]   count
);

    retire_rec_t mem [DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // Writing while full is only requested together with a pop, so the
    // overwritten slot is the head that leaves at this same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= pushRec;
        end
    end

    assign count = wrPtr - rdPtr;
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head  = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/retire_checker.sv
// rtl/retire_checker.sv - compares retired instructions against a golden stream; RETIRE_CHECKER_DISPLAY_EN adds record printing
module retire_checker
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ret_valid,
    input  logic [31:0]        ret_pc,
    input  logic [1:0]         ret_kind,
    input  logic [4:0]         ret_rd,
    input  logic [31:0]        ret_value,
    input  logic [31:0]        ret_addr,
    input  logic               ret_finish,
    input  logic               gold_valid,
    output logic               gold_ready,
    input  logic [31:0]        gold_pc,
    input  logic [1:0]         gold_kind,
    input  logic [4:0]         gold_rd,
    input  logic [31:0]        gold_value,
    input  logic [31:0]        gold_addr,
    input  logic               gold_finish,
    output logic               done,
    output logic               fail,
    output logic               overflow,
    output logic [CNT_W-1:0]   fail_index,
    output logic [31:0]        fail_pc,
    output logic [CNT_W-1:0]   retired_count
);

    localparam int AW = $clog2(DEPTH);

    check_state_t state;
    check_state_t stateNext;

    retire_rec_t retRec;
    retire_rec_t goldRec;
    retire_rec_t headRec;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [AW:0] fifoCount;

    logic running;
    logic handshake;
    logic pushReq;
    logic dropRec;
    logic fifoPush;
    logic isMatch;
    logic mismatch;
    logic goodCmp;

    assign retRec  = '{pc: ret_pc, kind: retire_kind_t'(ret_kind), rd: ret_rd,
                       value: ret_value, addr: ret_addr, finish: ret_finish};
    assign goldRec = '{pc: gold_pc, kind: retire_kind_t'(gold_kind), rd: gold_rd,
                       value: gold_value, addr: gold_addr, finish: gold_finish};

    retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifoPush),
        .pushRec (retRec),
        .pop     (handshake),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .head    (headRec),
        .count   (fifoCount)
    );

    assign running    = (state == ST_RUN);
    assign gold_ready = running && !fifoEmpty;
    assign handshake  = gold_valid && gold_ready;
    assign pushReq    = running && ret_valid;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign dropRec    = pushReq && fifoFull && !handshake;
    assign fifoPush   = pushReq && !dropRec;
    assign isMatch    = recordsMatch(normalize(headRec), normalize(goldRec));
    assign mismatch   = handshake && !isMatch;
    assign goodCmp    = handshake && isMatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_RUN: begin
                if (mismatch || dropRec) begin
                    stateNext = ST_FAIL;
                end else if (goodCmp && headRec.finish) begin
                    stateNext = ST_DONE;
                end
            end
            default: stateNext = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done          <= 1'b0;
            fail          <= 1'b0;
            overflow      <= 1'b0;
            fail_index    <= '0;
            fail_pc       <= '0;
            retired_count <= '0;
        end else if (running) begin
            if (goodCmp) begin
                retired_count <= retired_count + 1'b1;
                if (headRec.finish) begin
                    done <= 1'b1;
                end
            end
            if (mismatch) begin
                fail       <= 1'b1;
                fail_index <= retired_count;
                fail_pc    <= headRec.pc;
            end
            // Mismatch details win over the overflow position when both occur.
            if (dropRec) begin
                fail     <= 1'b1;
                overflow <= 1'b1;
                if (!mismatch) begin
                    fail_index <= retired_count + CNT_W'(fifoCount);
                    fail_pc    <= '0;
                end
            end
        end
    end

`ifdef RETIRE_CHECKER_DISPLAY_EN
    function automatic string recText(input retire_rec_t rec, input logic [CNT_W-1:0] num);
        string s;
        case (rec.kind)
            REG:     s = $sformatf("x%0d=0x%08h", rec.rd, rec.value);
            MEM:     s = $sformatf("M[0x%08h]=0x%08h", rec.addr, rec.value);
            default: s = $sformatf("NUM=%0d", num);
        endcase
        return $sformatf("%s PC=0x%08h", s, rec.pc);
    endfunction

    always @(posedge clk) begin
        if (!reset && running) begin
            if (goodCmp) begin
                $display("%s", recText(headRec, retired_count));
            end
            if (mismatch) begin
                $display("mismatch expected: %s", recText(goldRec, retired_count));
                $display("mismatch actual:   %s", recText(headRec, retired_count));
            end
            if (dropRec) begin
                $display("retire overflow: record PC=0x%08h dropped", ret_pc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_retire_checker.sv
// tb/tb_retire_checker.sv - randomized and directed checks of retire_checker against a queue model
module tb_retire_checker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] addr;
        logic        finish;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic ret_valid, ret_finish, gold_valid, gold_finish, gold_ready;
    logic [31:0] ret_pc, ret_value, ret_addr, gold_pc, gold_value, gold_addr;
    logic [1:0] ret_kind, gold_kind;
    logic [4:0] ret_rd, gold_rd;
    logic done, fail, overflow;
    logic [CNT_W-1:0] fail_index, retired_count;
    logic [31:0] fail_pc;

    int total = 0;
    int bad = 0;

    rec_t mQ[$];
    int   mState;
    logic mDone, mFail, mOvf;
    logic [31:0] mIdx, mPc, mCnt;
    bit   mHs;

    always #5 clk = ~clk;

    retire_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_kind(ret_kind), .ret_rd(ret_rd),
        .ret_value(ret_value), .ret_addr(ret_addr), .ret_finish(ret_finish),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc),
        .gold_kind(gold_kind), .gold_rd(gold_rd), .gold_value(gold_value),
        .gold_addr(gold_addr), .gold_finish(gold_finish),
        .done(done), .fail(fail), .overflow(overflow), .fail_index(fail_index),
        .fail_pc(fail_pc), .retired_count(retired_count)
    );

    function automatic rec_t mk(input logic [31:0] pc, input logic [1:0] kind, input logic [4:0] rd,
                                input logic [31:0] value, input logic [31:0] addr, input logic finish);
        rec_t r;
        r.pc = pc; r.kind = kind; r.rd = rd; r.value = value; r.addr = addr; r.finish = finish;
        return r;
    endfunction

    // Effective kind: a register write to x0 counts as no write at all.
    function automatic logic [1:0] effKind(input rec_t r);
        return (r.kind == 2'd1 && r.rd == 5'd0) ? 2'd0 : r.kind;
    endfunction

    function automatic bit modelMatch(input rec_t a, input rec_t g);
        if (a.pc != g.pc || a.finish != g.finish || effKind(a) != effKind(g)) return 0;
        if (effKind(a) == 2'd1) return (a.rd == g.rd) && (a.value == g.value);
        if (effKind(a) == 2'd2) return (a.addr == g.addr) && (a.value == g.value);
        return 1;
    endfunction

    task automatic setRet(input bit v, input rec_t r);
        ret_valid = v; ret_pc = r.pc; ret_kind = r.kind; ret_rd = r.rd;
        ret_value = r.value; ret_addr = r.addr; ret_finish = r.finish;
    endtask

    task automatic setGold(input bit v, input rec_t r);
        gold_valid = v; gold_pc = r.pc; gold_kind = r.kind; gold_rd = r.rd;
        gold_value = r.value; gold_addr = r.addr; gold_finish = r.finish;
    endtask

    task automatic modelReset();
        mQ.delete();
        mState = 0; mDone = 0; mFail = 0; mOvf = 0; mIdx = 0; mPc = 0; mCnt = 0; mHs = 0;
    endtask

    task automatic modelStep();
        rec_t a;
        rec_t g;
        bit run;
        run = (mState == 0);
        mHs = gold_valid && run && (mQ.size() > 0);
        if (!run) return;
        if (mHs) begin
            a = mQ.pop_front();
            g = mk(gold_pc, gold_kind, gold_rd, gold_value, gold_addr, gold_finish);
            if (modelMatch(a, g)) begin
                mCnt = mCnt + 1;
                if (a.finish) begin mDone = 1; mState = 1; end
            end else begin
                mFail = 1; mState = 2; mIdx = mCnt; mPc = a.pc;
            end
        end
        if (ret_valid) begin
            if (mQ.size() < DEPTH) begin
                mQ.push_back(mk(ret_pc, ret_kind, ret_rd, ret_value, ret_addr, ret_finish));
            end else begin
                mOvf = 1; mFail = 1; mState = 2; mIdx = mCnt + mQ.size(); mPc = 0;
            end
        end
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        setRet(0, mk(0, 0, 0, 0, 0, 0));
        setGold(0, mk(0, 0, 0, 0, 0, 0));
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        setRet(1, mk(32'h0, 1, 1, 5, 0, 0)); cycle();
        setRet(1, mk(32'h4, 1, 2, 6, 0, 0)); setGold(1, mk(32'h0, 1, 1, 5, 0, 0)); cycle();
        setGold(0, mk(0, 0, 0, 0, 0, 0));
        setRet(1, mk(32'h8, 1, 3, 7, 0, 0)); cycle();
        setRet(1, mk(32'hc, 1, 4, 8, 0, 0)); cycle();
        setRet(0, mk(0, 0, 0, 0, 0, 0));
        total++;
        if (retired_count !== 32'd1 || gold_ready !== 1'b1) begin
            bad++; $display("FAIL reset_prerun count=%0d ready=%b want count=1 ready=1", retired_count, gold_ready);
        end
        #1 reset = 1'b1;
        #1;
        modelReset();
        total++;
        if ({done, fail, overflow} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {done, fail, overflow});
        end
        total++;
        if (fail_index !== 0 || fail_pc !== 0 || retired_count !== 0) begin
            bad++; $display("FAIL reset_counts got idx=%0d pc=%h cnt=%0d want 0/0/0", fail_index, fail_pc, retired_count);
        end
        total++;
        if (gold_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0", gold_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        setGold(1, mk(32'h4, 1, 2, 6, 0, 0));
        #1;
        total++;
        if (gold_ready !== 1'b0) begin
            bad++; $display("FAIL reset_fifo_empty ready got=%b want=0", gold_ready);
        end
        setGold(0, mk(0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_clean_run();
        rec_t r0, r1, r2;
        r0 = mk(32'h0, 1, 1, 5, 0, 0);
        r1 = mk(32'h4, 2, 0, 7, 32'h100, 0);
        r2 = mk(32'h8, 0, 0, 0, 0, 1);
        applyReset();
        setRet(1, r0); cycle();
        setRet(1, r1); setGold(1, r0); cycle();
        setRet(1, r2); setGold(1, r1); cycle();
        setRet(0, r2); setGold(1, r2); cycle();
        total++;
        if ({done, fail, overflow} !== 3'b100 || retired_count !== 32'd3) begin
            bad++; $display("FAIL clean_run flags=%b cnt=%0d want flags=100 cnt=3", {done, fail, overflow}, retired_count);
        end
        total++;
        if (gold_ready !== 1'b0) begin
            bad++; $display("FAIL clean_ready_after_done got=%b want=0", gold_ready);
        end
        setGold(0, r2);
    endtask

    task automatic test_done_latency();
        applyReset();
        setRet(1, mk(32'h10, 0, 0, 0, 0, 1)); cycle();
        setRet(0, mk(0, 0, 0, 0, 0, 0));
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL done_early got=%b want=0", done);
        end
        setGold(1, mk(32'h10, 0, 0, 0, 0, 1)); cycle();
        total++;
        if (done !== 1'b1 || retired_count !== 32'd1) begin
            bad++; $display("FAIL done_latency done=%b cnt=%0d want 1/1", done, retired_count);
        end
        setGold(0, mk(0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_mismatch();
        applyReset();
        setRet(1, mk(32'h0, 1, 1, 5, 0, 0)); cycle();
        setRet(1, mk(32'h4, 1, 2, 8, 0, 0)); setGold(1, mk(32'h0, 1, 1, 5, 0, 0)); cycle();
        setRet(1, mk(32'h8, 0, 0, 0, 0, 0)); setGold(1, mk(32'h4, 1, 2, 9, 0, 0)); cycle();
        total++;
        if ({done, fail, overflow} !== 3'b010) begin
            bad++; $display("FAIL mismatch_flags got=%b want=010", {done, fail, overflow});
        end
        total++;
        if (fail_index !== 32'd1 || fail_pc !== 32'h4 || retired_count !== 32'd1) begin
            bad++; $display("FAIL mismatch_fields idx=%0d pc=%h cnt=%0d want 1/4/1", fail_index, fail_pc, retired_count);
        end
        total++;
        if (gold_ready !== 1'b0) begin
            bad++; $display("FAIL mismatch_ready got=%b want=0", gold_ready);
        end
        setGold(1, mk(32'h8, 0, 0, 0, 0, 0)); cycle();
        setRet(0, mk(0, 0, 0, 0, 0, 0)); setGold(0, mk(0, 0, 0, 0, 0, 0));
        total++;
        if (fail_index !== 32'd1 || retired_count !== 32'd1 || gold_ready !== 1'b0) begin
            bad++; $display("FAIL mismatch_frozen idx=%0d cnt=%0d ready=%b want 1/1/0", fail_index, retired_count, gold_ready);
        end
    endtask

    task automatic test_overflow();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            setRet(1, mk(32'h4 * i, 1, 5'(i + 1), i, 0, 0)); cycle();
        end
        total++;
        if ({fail, overflow} !== 2'b00) begin
            bad++; $display("FAIL overflow_at_full got=%b want=00", {fail, overflow});
        end
        setRet(1, mk(32'h10, 1, 5, 5, 0, 0)); cycle();
        setRet(0, mk(0, 0, 0, 0, 0, 0));
        total++;
        if ({done, fail, overflow} !== 3'b011 || fail_index !== 32'd4 || fail_pc !== 32'd0) begin
            bad++; $display("FAIL overflow flags=%b idx=%0d pc=%h want 011/4/0", {done, fail, overflow}, fail_index, fail_pc);
        end
    endtask

    task automatic test_full_pop();
        rec_t r[5];
        applyReset();
        for (int i = 0; i < 5; i++) r[i] = mk(32'h40 + 4 * i, 2, 0, i, 32'h200 + i, 0);
        for (int i = 0; i < 4; i++) begin
            setRet(1, r[i]); cycle();
        end
        setRet(1, r[4]); setGold(1, r[0]); cycle();
        setRet(0, r[0]);
        total++;
        if ({fail, overflow} !== 2'b00 || retired_count !== 32'd1) begin
            bad++; $display("FAIL full_pop flags=%b cnt=%0d want 00/1", {fail, overflow}, retired_count);
        end
        for (int i = 1; i < 5; i++) begin
            total++;
            if (gold_ready !== 1'b1) begin
                bad++; $display("FAIL full_pop_ready%0d got=%b want=1", i, gold_ready);
            end
            setGold(1, r[i]); cycle();
        end
        total++;
        if (retired_count !== 32'd5 || gold_ready !== 1'b0 || fail !== 1'b0) begin
            bad++; $display("FAIL full_pop_drain cnt=%0d ready=%b fail=%b want 5/0/0", retired_count, gold_ready, fail);
        end
        setGold(0, r[0]);
    endtask

    task automatic test_x0_normalize();
        applyReset();
        setRet(1, mk(32'h20, 1, 0, 3, 0, 0)); cycle();
        setRet(1, mk(32'h24, 0, 0, 0, 0, 0)); setGold(1, mk(32'h20, 0, 9, 32'h55, 32'h66, 0)); cycle();
        setRet(1, mk(32'h28, 1, 0, 3, 0, 0)); setGold(1, mk(32'h24, 1, 0, 7, 0, 0)); cycle();
        setRet(0, mk(0, 0, 0, 0, 0, 0));
        total++;
        if (retired_count !== 32'd2 || fail !== 1'b0) begin
            bad++; $display("FAIL x0_match cnt=%0d fail=%b want 2/0", retired_count, fail);
        end
        setGold(1, mk(32'h28, 1, 1, 3, 0, 0)); cycle();
        setGold(0, mk(0, 0, 0, 0, 0, 0));
        total++;
        if (fail !== 1'b1 || fail_index !== 32'd2 || fail_pc !== 32'h28) begin
            bad++; $display("FAIL x0_vs_x1 fail=%b idx=%0d pc=%h want 1/2/28", fail, fail_index, fail_pc);
        end
    endtask

    task automatic test_random();
        rec_t gq[$];
        rec_t r, g;
        int goldPct;
        for (int ep = 0; ep < 6; ep++) begin
            applyReset();
            gq.delete();
            goldPct = (ep % 3 == 0) ? 20 : 70;
            for (int cyc = 0; cyc < 200; cyc++) begin
                if (gq.size() > 0 && $urandom_range(0, 99) < goldPct) setGold(1, gq[0]);
                else setGold(0, mk($urandom, 0, 0, 0, 0, 0));
                if ($urandom_range(0, 99) < 60) begin
                    r = mk(32'h1000 + 4 * cyc, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 3)),
                           $urandom_range(0, 15), $urandom, ($urandom_range(0, 199) == 0));
                    g = r;
                    if (effKind(r) == 2'd0) begin
                        g.rd = 5'($urandom); g.value = $urandom; g.addr = $urandom;
                        if ($urandom_range(0, 1) == 1 && r.kind == 2'd1) g.kind = 2'd0;
                    end else if (r.kind == 2'd1) begin
                        g.addr = $urandom;
                    end else begin
                        g.rd = 5'($urandom);
                    end
                    if ($urandom_range(0, 59) == 0) begin
                        if (effKind(r) == 2'd0) g.pc = g.pc ^ 32'h4;
                        else g.value = g.value ^ 32'h1;
                    end
                    setRet(1, r);
                    gq.push_back(g);
                end else begin
                    setRet(0, mk(0, 0, 0, 0, 0, 0));
                end
                #1;
                total++;
                if (gold_ready !== (mState == 0 && mQ.size() > 0)) begin
                    bad++; $display("FAIL rand_ready ep%0d cyc%0d got=%b want=%b", ep, cyc, gold_ready, (mState == 0 && mQ.size() > 0));
                end
                cycle();
                if (mHs) void'(gq.pop_front());
                total++;
                if ({done, fail, overflow, fail_index, fail_pc, retired_count} !== {mDone, mFail, mOvf, mIdx, mPc, mCnt}) begin
                    bad++;
                    $display("FAIL rand_outputs ep%0d cyc%0d got d=%b f=%b o=%b idx=%0d pc=%h cnt=%0d want d=%b f=%b o=%b idx=%0d pc=%h cnt=%0d",
                             ep, cyc, done, fail, overflow, fail_index, fail_pc, retired_count,
                             mDone, mFail, mOvf, mIdx, mPc, mCnt);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        setRet(0, mk(0, 0, 0, 0, 0, 0));
        setGold(0, mk(0, 0, 0, 0, 0, 0));
        modelReset();
        test_reset();
        test_clean_run();
        test_done_latency();
        test_mismatch();
        test_overflow();
        test_full_pop();
        test_x0_normalize();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_checker.md
# retire_checker

Simulation-side consumer of the core's writeback retirement stream. Every retired instruction (PC, register write or memory store, finish flag) is buffered in a small FIFO and compared one-for-one against a golden record stream delivered over a valid/ready handshake. The block sits beside the pipeline top, fed from writeback-stage signals, and reports pass/fail, the first mismatch and retirement counts to the testbench.

## Interface
- DEPTH, 8: retire FIFO entries; power of two, minimum 2.
- CNT_W, 32: width of retired_count and fail_index.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ret_valid  in  1  one instruction retires this cycle; no backpressure.
- ret_pc  in  32  PC of the retiring instruction.
- ret_kind  in  2  NONE=0, REG=1, MEM=2.
- ret_rd  in  5  destination register (REG).
- ret_value  in  32  register result (REG) or store data (MEM).
- ret_addr  in  32  store address (MEM).
- ret_finish  in  1  last instruction of the program.
- gold_valid  in  1  golden record presented.
- gold_ready  out  1  golden record accepted this cycle when gold_valid is also high.
- gold_pc, gold_kind, gold_rd, gold_value, gold_addr, gold_finish  in  32/2/5/32/32/1  expected fields, same encoding.
- done  out  1  finish record compared successfully.
- fail  out  1  mismatch or overflow detected.
- overflow  out  1  a retirement was dropped because the FIFO was full.
- fail_index  out  CNT_W  0-based index of the failing record.
- fail_pc  out  32  actual PC of the failing record (0 on overflow).
- retired_count  out  CNT_W  records compared successfully.

## Operation
- States: RUN, DONE, FAIL. Reset enters RUN.
- Push: in RUN, ret_valid writes the record into the FIFO.
- gold_ready = (state==RUN) && FIFO not empty. A handshake pops the FIFO head and compares it with the gold fields.
- Normalization: REG with rd==0 is treated as NONE on both sides before comparison.
- Match rule: pc, kind and finish are always equal; REG additionally requires equal rd and value; MEM requires equal addr and value; NONE ignores rd/value/addr.
- On a match: retired_count increments. If finish is set, the state moves to DONE.
- On a mismatch: the state moves to FAIL, fail_index is set to the current retired_count, and fail_pc is set to the actual pc.
- Overflow: a push while the FIFO is full with no pop in the same cycle drops the record. overflow=1, state moves to FAIL, fail_index = retired_count + occupancy, fail_pc=0.
- A push and a pop in the same cycle while full is legal: occupancy is unchanged and no overflow occurs.
- DONE and FAIL are terminal until reset. In these states gold_ready=0, pushes are ignored, and all outputs are frozen.
- If a mismatch and an overflow occur in the same cycle, both are recorded: overflow=1 and the mismatch fields are reported.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset value of every output is 0, and the FIFO is emptied. Asserting reset mid-run clears everything immediately.
- Push-to-pop latency is 1 cycle: a record pushed at edge N can handshake at edge N+1. There is no bypass path.
- gold_ready is combinational from state and FIFO occupancy only, never from gold_valid.
- done, fail, overflow, fail_index, fail_pc and retired_count update at the edge of the causing handshake or push. They are visible in the following cycle.
- The block sustains one compare per cycle.

## Configuration
- RETIRE_CHECKER_DISPLAY_EN
  - Defined: $display prints each compared record as "NUM=n", "x<rd>=0x<v>" or "M[0x<a>]=0x<v>", then "PC=0x<pc>". A mismatch prints both expected and actual records. Overflow prints a one-line message.
  - Undefined: no display statements are compiled, and behaviour is otherwise identical.

## Structure
- Package riscv_trace_pkg holds:
  - the retire_kind_t enum (NONE/REG/MEM);
  - the retire_rec_t packed struct (pc, kind, rd, value, addr, finish);
  - the checker state enum;
  - a normalize function.
- Sub-module retire_fifo: parameterized synchronous FIFO of retire_rec_t.
  - Ports: push, pop, full, empty, head, count.
  - Wrap-around pointers with an extra MSB.

## Test plan
- Reset: assert reset mid-run with 3 records buffered -> all outputs 0, gold_ready=0, FIFO empty the next cycle.
- Clean run: retire x1=0x5 @0x0, M[0x100]=0x7 @0x4, NONE+finish @0x8, with matching gold -> done=1 the cycle after the third handshake, retired_count=3, fail=0.
- Mismatch: the second record is x2=0x8 while gold expects x2=0x9 -> fail=1, fail_index=1, fail_pc=0x4, retired_count=1, gold_ready=0 thereafter.
- Overflow: DEPTH=4, gold_valid=0, five consecutive retirements -> overflow=1, fail=1, fail_index=4, fail_pc=0.
- Full plus simultaneous pop: fill 4 entries, then retire and handshake in the same cycle -> overflow=0, occupancy stays 4.
- x0 normalization: actual REG rd=0 value=0x3 against gold NONE at the same pc -> match, retired_count increments.
